// File: rtl/ledboard_fifo_reader.sv
// Drains a first-word-fall-through FIFO onto the LED board serial chain (sclk/sdata/latch).
// Define LEDBOARD_READER_LSB_FIRST_EN to shift each word out LSB first instead of MSB first.
module ledboard_fifo_reader #(
  parameter int WIDTH           = 8,
  parameter int CLK_DIV         = 4,
  parameter int BYTES_PER_FRAME = 8,
  parameter int LATCH_CYCLES    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             read_en,
  output logic             led_sclk,
  output logic             led_sdata,
  output logic             led_latch,
  output logic             busy,
  output logic             frame_done
);

  localparam int BIT_W  = $clog2(WIDTH) + 1;
  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int BYTE_W = $clog2(BYTES_PER_FRAME) + 1;
  localparam int LAT_W  = $clog2(LATCH_CYCLES) + 1;

  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(BYTES_PER_FRAME - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_PENULT = LAT_W'((LATCH_CYCLES >= 2) ? LATCH_CYCLES - 2 : 0);
  localparam logic              LAT_ONE    = (LATCH_CYCLES == 1);

`ifdef LEDBOARD_READER_LSB_FIRST_EN
  localparam int OUT_BIT = 0;
`else
  localparam int OUT_BIT = WIDTH - 1;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    shift_reg, shift_nxt, shifted;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DIV_W-1:0]    div_cnt, div_nxt;
  logic [BYTE_W-1:0]   byte_cnt, byte_nxt;
  logic [LAT_W-1:0]    lat_cnt, lat_nxt;
  logic                sclk_nxt, sdata_nxt, latch_nxt, busy_nxt, done_nxt;

`ifdef LEDBOARD_READER_LSB_FIRST_EN
  assign shifted = shift_reg >> 1;
`else
  assign shifted = shift_reg << 1;
`endif

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    bit_nxt   = bit_cnt;
    div_nxt   = div_cnt;
    byte_nxt  = byte_cnt;
    lat_nxt   = lat_cnt;
    sclk_nxt  = led_sclk;
    sdata_nxt = led_sdata;
    latch_nxt = led_latch;
    done_nxt  = 1'b0;
    read_en   = 1'b0;
    unique case (state)
      IDLE, FETCH: begin
        // Waiting here keeps sdata at the last bit; the frame resumes from byte_cnt.
        sclk_nxt = 1'b0;
        if (!fifo_empty && enable && rst) begin
          read_en   = 1'b1;
          shift_nxt = fifo_data;
          sdata_nxt = fifo_data[OUT_BIT];
          bit_nxt   = '0;
          div_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!led_sclk) begin
            sclk_nxt = 1'b1;
          end else begin
            sclk_nxt = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              byte_nxt = byte_cnt + BYTE_W'(1);
              if (byte_cnt == BYTE_LAST) begin
                state_nxt = LATCH;
                latch_nxt = 1'b1;
                lat_nxt   = '0;
                done_nxt  = LAT_ONE;
              end else begin
                state_nxt = FETCH;
              end
            end else begin
              bit_nxt   = bit_cnt + BIT_W'(1);
              shift_nxt = shifted;
              sdata_nxt = shifted[OUT_BIT];
            end
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      LATCH: begin
        if (lat_cnt == LAT_LAST) begin
          state_nxt = IDLE;
          latch_nxt = 1'b0;
          byte_nxt  = '0;
        end else begin
          lat_nxt  = lat_cnt + LAT_W'(1);
          done_nxt = (lat_cnt == LAT_PENULT);
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      byte_cnt   <= '0;
      lat_cnt    <= '0;
      led_sclk   <= 1'b0;
      led_sdata  <= 1'b0;
      led_latch  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      byte_cnt   <= byte_nxt;
      lat_cnt    <= lat_nxt;
      led_sclk   <= sclk_nxt;
      led_sdata  <= sdata_nxt;
      led_latch  <= latch_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

endmodule

// File: tb/tb_ledboard_fifo_reader.sv
// Directed bench for ledboard_fifo_reader with a behavioural FWFT FIFO and a bit-capturing monitor.
module tb_ledboard_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       read_en, led_sclk, led_sdata, led_latch, busy, frame_done;

  always #5 clk = ~clk;

  ledboard_fifo_reader #(
    .WIDTH(8), .CLK_DIV(2), .BYTES_PER_FRAME(3), .LATCH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .read_en(read_en), .led_sclk(led_sclk), .led_sdata(led_sdata), .led_latch(led_latch),
    .busy(busy), .frame_done(frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr % 32];

  int   cyc = 0, rd_cnt = 0, rd_cyc = 0, bad_rd = 0;
  logic prev_rd = 1'b0;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (read_en === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc = cyc;
      if (fifo_empty) bad_rd = bad_rd + 1;
      if (prev_rd) bad_rd = bad_rd + 1;
      rd_ptr <= rd_ptr + 1;
    end
    prev_rd = (read_en === 1'b1);
  end

  logic bitlog [512];
  int   rise_cyc [512];
  int   rise_cnt = 0, latch_hi = 0, latch_cnt = 0, latch_rise_cyc = 0, done_cnt = 0;
  int   bad_latch = 0, last_lat = 0, lat_seen = 0;
  logic prev_sclk = 1'b0, prev_latch = 1'b0;
  always @(negedge clk) begin
    if (led_sclk === 1'b1 && !prev_sclk) begin
      bitlog[rise_cnt % 512]   = led_sdata;
      rise_cyc[rise_cnt % 512] = cyc;
      rise_cnt = rise_cnt + 1;
      if (rd_cnt != lat_seen) begin
        last_lat = cyc - rd_cyc;
        lat_seen = rd_cnt;
      end
    end
    if (led_latch === 1'b1) begin
      latch_hi = latch_hi + 1;
      if (led_sclk !== 1'b0) bad_latch = bad_latch + 1;
      if (!prev_latch) begin
        latch_cnt = latch_cnt + 1;
        latch_rise_cyc = cyc;
      end
    end
    if (frame_done === 1'b1) done_cnt = done_cnt + 1;
    prev_sclk  = (led_sclk === 1'b1);
    prev_latch = (led_latch === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 32] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int snap, input string tag);
    int k = 0;
    while (done_cnt == snap && k < 1000) begin
      step(1);
      k++;
    end
    chk(tag, 32'(done_cnt - snap), 32'd1);
  endtask

  // Transmission order of a byte, written MSB of the result = first bit on the wire.
  function automatic logic [7:0] ord(input logic [7:0] b);
    logic [7:0] r;
`ifdef LEDBOARD_READER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  function automatic logic [23:0] pack24(input int base);
    logic [23:0] v = '0;
    for (int i = 0; i < 24; i++) v = {v[22:0], bitlog[(base + i) % 512]};
    return v;
  endfunction

  initial begin
    int rs, rd0, lc0, lh0, d0, k;
    logic [7:0] tmp;

    // 1: reset with a non-empty FIFO and enable high
    push(8'h01); push(8'h02); push(8'h03);
    enable = 1'b1;
    rst    = 1'b0;
    step(1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_read_en", 32'(read_en), 32'd0);
      chk("rst_outputs", 32'({led_sclk, led_sdata, led_latch, busy, frame_done}), 32'd0);
      step(1);
    end
    chk("rst_no_reads", 32'(rd_cnt), 32'd0);

    // 2: preloaded 01 02 03
    rs = rise_cnt; rd0 = rd_cnt; lc0 = latch_cnt; lh0 = latch_hi; d0 = done_cnt;
    rst = 1'b1;
    wait_done(d0, "t2_frame_done");
    chk("t2_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t2_rises", 32'(rise_cnt - rs), 32'd24);
    chk("t2_bits", 32'(pack24(rs)), 32'({ord(8'h01), ord(8'h02), ord(8'h03)}));
`ifdef LEDBOARD_READER_LSB_FIRST_EN
    chk("t2_first_bit", 32'(bitlog[rs % 512]), 32'd1);
`else
    chk("t2_first_bit", 32'(bitlog[rs % 512]), 32'd0);
`endif
    chk("t2_bit_period", 32'(rise_cyc[(rs + 1) % 512] - rise_cyc[rs % 512]), 32'd4);
    chk("t2_byte_gap", 32'(rise_cyc[(rs + 8) % 512] - rise_cyc[(rs + 7) % 512]), 32'd5);
    chk("t2_rd_to_sclk", 32'(last_lat), 32'd2);
    chk("t2_latch_cycles", 32'(latch_hi - lh0), 32'd2);
    chk("t2_latch_pulses", 32'(latch_cnt - lc0), 32'd1);
    chk("t2_latch_after_bit", 32'(latch_rise_cyc - rise_cyc[(rs + 23) % 512]), 32'd2);
    step(1);
    chk("t2_busy_after", 32'({busy, led_latch}), 32'd0);

    // 3: underrun after the first byte
    rs = rise_cnt; rd0 = rd_cnt; lc0 = latch_cnt; d0 = done_cnt;
    push(8'hAA);
    step(40);
    tmp = ord(8'hAA);
    chk("t3_stall_rises", 32'(rise_cnt - rs), 32'd8);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    chk("t3_stall_sclk", 32'(led_sclk), 32'd0);
    chk("t3_stall_sdata", 32'(led_sdata), 32'(tmp[0]));
    step(10);
    chk("t3_stall_rises2", 32'(rise_cnt - rs), 32'd8);
    chk("t3_stall_busy2", 32'(busy), 32'd1);
    chk("t3_no_latch", 32'(latch_cnt - lc0), 32'd0);
    push(8'hBB); push(8'hCC);
    wait_done(d0, "t3_frame_done");
    chk("t3_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t3_bits", 32'(pack24(rs)), 32'({ord(8'hAA), ord(8'hBB), ord(8'hCC)}));
    chk("t3_latch_after_bit", 32'(latch_rise_cyc - rise_cyc[(rs + 23) % 512]), 32'd2);
    step(1);

    // 4: reset at the 3rd sclk rise of the first byte
    rs = rise_cnt; rd0 = rd_cnt; lc0 = latch_cnt; lh0 = latch_hi;
    push(8'h11); push(8'h22); push(8'h33);
    k = 0;
    while (rise_cnt < rs + 3 && k < 200) begin
      step(1);
      k++;
    end
    chk("t4_third_rise", 32'(rise_cnt - rs), 32'd3);
    rst = 1'b0;
    step(1);
    chk("t4_outputs", 32'({led_sclk, led_sdata, led_latch, busy, frame_done}), 32'd0);
    chk("t4_read_en", 32'(read_en), 32'd0);
    step(1);
    chk("t4_read_en2", 32'(read_en), 32'd0);
    chk("t4_reads", 32'(rd_cnt - rd0), 32'd1);
    chk("t4_no_latch", 32'(latch_hi - lh0), 32'd0);
    push(8'h44);
    rs = rise_cnt; rd0 = rd_cnt; d0 = done_cnt;
    rst = 1'b1;
    wait_done(d0, "t4_frame_done");
    chk("t4_fresh_bits", 32'(pack24(rs)), 32'({ord(8'h22), ord(8'h33), ord(8'h44)}));
    chk("t4_fresh_reads", 32'(rd_cnt - rd0), 32'd3);
    step(1);

    // 5: enable gating
    enable = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88); push(8'h99);
    rs = rise_cnt; rd0 = rd_cnt; lc0 = latch_cnt; d0 = done_cnt;
    step(100);
    chk("t5_disabled_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("t5_disabled_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    k = 0;
    while (rd_cnt < rd0 + 2 && k < 200) begin
      step(1);
      k++;
    end
    chk("t5_second_read", 32'(rd_cnt - rd0), 32'd2);
    enable = 1'b0;
    step(60);
    chk("t5_byte2_done", 32'(rise_cnt - rs), 32'd16);
    chk("t5_hold_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("t5_hold_busy", 32'(busy), 32'd1);
    chk("t5_hold_sclk", 32'(led_sclk), 32'd0);
    chk("t5_hold_latch", 32'(latch_cnt - lc0), 32'd0);
    enable = 1'b1;
    wait_done(d0, "t5_frame_done");
    enable = 1'b0;
    chk("t5_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t5_bits", 32'(pack24(rs)), 32'({ord(8'h55), ord(8'h66), ord(8'h77)}));
    step(3);

    chk("read_en_protocol", 32'(bad_rd), 32'd0);
    chk("latch_sclk_low", 32'(bad_latch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
